// File: rtl/mv_pkg.sv
// Shared state encodings, geometry constants and element extraction for the matvec sequencer.
package mv_pkg;

  localparam int NUM_WORDS      = 9;
  localparam int ELEMS_PER_WORD = 8;
  localparam int WORD_BITS      = 64;
  localparam int ELEM_BITS      = WORD_BITS / ELEMS_PER_WORD;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    REQ,
    RESP,
    UNPACK,
    RUN,
    DRAIN,
    FIN
  } mv_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_RESP
  } rd_state_t;

  // Element 0 is the most significant byte of the word.
  function automatic logic [ELEM_BITS-1:0] word_elem(input logic [WORD_BITS-1:0] word,
                                                     input logic [2:0]           idx);
    logic [WORD_BITS-1:0] sh;
    sh = word >> {~idx, 3'b000};
    return sh[ELEM_BITS-1:0];
  endfunction

endpackage

// File: rtl/avm_word_reader.sv
// Single-outstanding Avalon-MM word reader: holds read/address until waitrequest drops,
// then captures the first readdatavalid beat and returns a one-cycle word_vld pulse.
module avm_word_reader
  import mv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 word_req,
  input  logic [31:0]          word_addr,
  output logic                 word_vld,
  output logic [WORD_BITS-1:0] word_dat,
  output logic [31:0]          avm_address,
  output logic                 avm_read,
  input  logic [WORD_BITS-1:0] avm_readdata,
  input  logic                 avm_readdatavalid,
  input  logic                 avm_waitrequest
);

  rd_state_t st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= RD_IDLE;
      avm_address <= '0;
      avm_read    <= 1'b0;
      word_vld    <= 1'b0;
      word_dat    <= '0;
    end else begin
      word_vld <= 1'b0;
      case (st)
        RD_IDLE: begin
          if (word_req) begin
            avm_address <= word_addr;
            avm_read    <= 1'b1;
            st          <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            st       <= RD_RESP;
          end
        end
        RD_RESP: begin
          // readdatavalid seen in any other state belongs to no request of ours
          if (avm_readdatavalid) begin
            word_dat <= avm_readdata;
            word_vld <= 1'b1;
            st       <= RD_IDLE;
          end
        end
        default: st <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/matvec_sequencer.sv
// Loads B and eight A rows from memory into nine FIFOs, then streams 8 elements into the MAC chain.
// Writes stall per-FIFO on wrfull; reads stall while any FIFO is empty; one memory read in flight.
module matvec_sequencer
  import mv_pkg::*;
#(
  parameter int          DATA_WIDTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'd0,
  parameter int          DRAIN_CYCLES = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           avm_address,
  output logic                  avm_read,
  input  logic [63:0]           avm_readdata,
  input  logic                  avm_readdatavalid,
  input  logic                  avm_waitrequest,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic [8:0]            fifo_wrreq,
  input  logic [8:0]            fifo_wrfull,
  output logic                  fifo_rdreq,
  input  logic [8:0]            fifo_rdempty,
  output logic                  mac_clr,
  output logic                  mac_en
);

  mv_state_t      state;
  logic [3:0]     w;
  logic [2:0]     k;
  logic [2:0]     n;
  logic [15:0]    d;

  logic           word_req;
  logic [31:0]    word_addr;
  logic           word_vld;
  logic [63:0]    word_dat;
  logic           wr_acc;
  logic           last_elem;
  logic           last_word;

  assign last_word = (w == 4'(NUM_WORDS - 1));
  assign last_elem = (k == 3'(ELEMS_PER_WORD - 1));
  assign wr_acc    = (state == UNPACK) && !fifo_wrfull[w];

  // Next word is requested in the same cycle its predecessor's last element is accepted.
  assign word_req  = (state == CLEAR) || (wr_acc && last_elem && !last_word);
  assign word_addr = BASE_ADDR + ((state == CLEAR) ? 32'd0 : (32'(w) + 32'd1));

  assign fifo_wrreq = wr_acc ? (9'd1 << w) : 9'd0;
  assign fifo_wdata = (state == UNPACK) ? DATA_WIDTH'(word_elem(word_dat, k)) : '0;
  assign fifo_rdreq = (state == RUN) && (fifo_rdempty == 9'd0);

  avm_word_reader u_reader (
    .clk               (clk),
    .rst_n             (rst_n),
    .word_req          (word_req),
    .word_addr         (word_addr),
    .word_vld          (word_vld),
    .word_dat          (word_dat),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      w       <= '0;
      k       <= '0;
      n       <= '0;
      d       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      mac_clr <= 1'b0;
      mac_en  <= 1'b0;
    end else begin
      // FIFO read data appears one cycle after rdreq
      mac_en <= fifo_rdreq;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            mac_clr <= 1'b1;
            w       <= '0;
          end
        end
        CLEAR: begin
          mac_clr <= 1'b0;
          w       <= '0;
          state   <= REQ;
        end
        REQ: begin
          if (avm_read && !avm_waitrequest) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (word_vld) begin
            k     <= '0;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          if (wr_acc) begin
            k <= k + 3'd1;
            if (last_elem) begin
              if (last_word) begin
                n     <= '0;
                state <= RUN;
              end else begin
                w     <= w + 4'd1;
                state <= REQ;
              end
            end
          end
        end
        RUN: begin
          if (fifo_rdreq) begin
            n <= n + 3'd1;
            if (n == 3'(ELEMS_PER_WORD - 1)) begin
              d     <= '0;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // first DRAIN cycle carries the final mac_en, then DRAIN_CYCLES more
          if (d == 16'(DRAIN_CYCLES)) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            d <= d + 16'd1;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_sequencer.sv
// Directed bench: memory/FIFO model driven per cycle, immediate-assertion checks per run.
module tb_matvec_sequencer;

  localparam logic [31:0] BASE  = 32'h0000_0040;
  localparam int          DRAIN = 9;
  localparam int          LAT   = 2;
  localparam int          T_NOM = 1 + 9 * (2 + LAT + 8) + 8 + 1 + DRAIN + 1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [63:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;
  logic [7:0]  fifo_wdata;
  logic [8:0]  fifo_wrreq;
  logic [8:0]  fifo_wrfull;
  logic        fifo_rdreq;
  logic [8:0]  fifo_rdempty;
  logic        mac_clr;
  logic        mac_en;

  matvec_sequencer #(
    .DATA_WIDTH   (8),
    .BASE_ADDR    (BASE),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest),
    .fifo_wdata        (fifo_wdata),
    .fifo_wrreq        (fifo_wrreq),
    .fifo_wrfull       (fifo_wrfull),
    .fifo_rdreq        (fifo_rdreq),
    .fifo_rdempty      (fifo_rdempty),
    .mac_clr           (mac_clr),
    .mac_en            (mac_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  bit          start_drv;
  bit          pend;
  int          pcnt;
  logic [31:0] paddr;
  bit          spurious;
  bit          wait_started;
  int          wait_left, full_left, empty_left;
  int          busy_cyc, done_cnt, clr_cnt, rd_total, mac_total, wr_total, viol;
  int          stall_cyc, full_cyc, empty_cyc;
  logic        prev_rdreq;
  bit          seen_done;
  logic [7:0]  wdat [9][8];
  int          wcnt [9];
  int          worder[$];
  logic [31:0] acc_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [31:0] addr);
    if (addr == BASE) return 64'h0102_0304_0506_0708;
    if ((addr > BASE) && (addr <= BASE + 32'd8)) return {8{8'h11}};
    return 64'hEEEE_EEEE_EEEE_EEEE;
  endfunction

  task automatic clear_stats();
    busy_cyc = 0; done_cnt = 0; clr_cnt = 0; rd_total = 0; mac_total = 0;
    wr_total = 0; viol = 0; stall_cyc = 0; full_cyc = 0; empty_cyc = 0;
    prev_rdreq = 1'b0; seen_done = 1'b0; wait_started = 1'b0;
    for (int b = 0; b < 9; b++) wcnt[b] = 0;
    worder.delete();
    acc_q.delete();
  endtask

  // One clock cycle: drive inputs at negedge, sample outputs 1 time unit later.
  task automatic tick();
    @(negedge clk);
    start             = start_drv;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    if (spurious) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = 64'hA5A5_A5A5_A5A5_A5A5;
      spurious          = 1'b0;
    end else if (pend) begin
      if (pcnt <= 1) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = mem_word(paddr);
        pend              = 1'b0;
      end else begin
        pcnt--;
      end
    end
    avm_waitrequest = avm_read && (wait_left > 0) && (wait_started || (avm_address == BASE + 32'd3));
    if (avm_waitrequest) begin
      wait_started = 1'b1;
      wait_left--;
      stall_cyc++;
    end
    fifo_wrfull = '0;
    if (full_left > 0 && wcnt[4] == 3) begin
      fifo_wrfull[4] = 1'b1;
      full_left--;
      full_cyc++;
    end
    fifo_rdempty = '0;
    if (empty_left > 0 && rd_total == 3) begin
      fifo_rdempty[2] = 1'b1;
      empty_left--;
      empty_cyc++;
    end
    #1;
    if (busy) busy_cyc++;
    if (done) begin done_cnt++; seen_done = 1'b1; end
    if (mac_clr) clr_cnt++;
    if (avm_waitrequest && (avm_address != BASE + 32'd3 || fifo_wrreq != 9'd0)) viol++;
    if (wait_started && wait_left > 0 && !avm_read) viol++;
    if (fifo_wrreq != 9'd0) begin
      if ($countones(fifo_wrreq) != 1) viol++;
      for (int b = 0; b < 9; b++) begin
        if (fifo_wrreq[b]) begin
          if (fifo_wrfull[b]) viol++;
          if (wcnt[b] < 8) wdat[b][wcnt[b]] = fifo_wdata;
          else viol++;
          wcnt[b]++;
          worder.push_back(b);
          wr_total++;
        end
      end
    end
    if (fifo_rdreq) begin
      if (fifo_rdempty != 9'd0 || !busy) viol++;
      rd_total++;
    end
    if (mac_en !== prev_rdreq) viol++;
    if (mac_en) mac_total++;
    prev_rdreq = fifo_rdreq;
    if (avm_read && !avm_waitrequest) begin
      pend  = 1'b1;
      pcnt  = LAT;
      paddr = avm_address;
      acc_q.push_back(avm_address);
    end
  endtask

  task automatic run_to_done(input string tag);
    int guard;
    guard = 0;
    while (!seen_done && guard < 3000) begin
      tick();
      guard++;
    end
    check({tag, "_done_seen"}, 64'(seen_done), 64'd1);
  endtask

  task automatic check_run(input string tag, input int exp_cyc);
    bit ok_addr, ok_order, ok_data;
    ok_addr = (acc_q.size() == 9);
    foreach (acc_q[i]) if (acc_q[i] != BASE + 32'(i)) ok_addr = 1'b0;
    ok_order = (worder.size() == 72);
    foreach (worder[i]) if (worder[i] != i / 8) ok_order = 1'b0;
    ok_data = 1'b1;
    for (int b = 0; b < 9; b++) begin
      if (wcnt[b] != 8) ok_data = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (wdat[b][i] !== ((b == 0) ? 8'(i + 1) : 8'h11)) ok_data = 1'b0;
      end
    end
    check({tag, "_cycles"},    64'(busy_cyc),  64'(exp_cyc));
    check({tag, "_done_cnt"},  64'(done_cnt),  64'd1);
    check({tag, "_clr_cnt"},   64'(clr_cnt),   64'd1);
    check({tag, "_rdreq_cnt"}, 64'(rd_total),  64'd8);
    check({tag, "_mac_cnt"},   64'(mac_total), 64'd8);
    check({tag, "_wr_cnt"},    64'(wr_total),  64'd72);
    check({tag, "_addr_seq"},  64'(ok_addr),   64'd1);
    check({tag, "_wr_order"},  64'(ok_order),  64'd1);
    check({tag, "_wr_data"},   64'(ok_data),   64'd1);
    check({tag, "_protocol"},  64'(viol),      64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_drv = 1'b0;
    avm_readdata = '0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    fifo_wrfull = '0; fifo_rdempty = '0;
    pend = 1'b0; pcnt = 0; paddr = '0; spurious = 1'b0;
    wait_left = 0; full_left = 0; empty_left = 0;
    clear_stats();
    #2;
    check("reset_ctrl", 64'({busy, done, avm_read, fifo_wrreq, fifo_rdreq, mac_clr, mac_en, fifo_wdata}), 64'd0);
    check("reset_addr", 64'(avm_address), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    // Plain run
    clear_stats();
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    run_to_done("run1");
    check_run("run1", T_NOM);
    tick();
    check("run1_idle_after", 64'({busy, done}), 64'd0);

    // Stalls on memory, one write FIFO and one read FIFO; start held throughout
    clear_stats();
    wait_left = 5; full_left = 3; empty_left = 2;
    start_drv = 1'b1;
    tick();
    run_to_done("run2");
    check_run("run2", T_NOM + 5 + 3 + 2);
    check("run2_wait_cyc",  64'(stall_cyc), 64'd5);
    check("run2_full_cyc",  64'(full_cyc),  64'd3);
    check("run2_empty_cyc", 64'(empty_cyc), 64'd2);
    tick();
    check("fin_then_idle", 64'(busy), 64'd0);
    clear_stats();
    tick();
    check("restart_clear", 64'({busy, mac_clr}), 64'b11);
    start_drv = 1'b0;

    // Reset while word 5 response is outstanding
    begin
      int guard;
      guard = 0;
      while (acc_q.size() < 6 && guard < 2000) begin
        tick();
        guard++;
      end
    end
    check("run3_w5_addr", 64'((acc_q.size() > 5) ? acc_q[5] : 32'd0), 64'(BASE + 32'd5));
    @(posedge clk);
    #2;
    check("run3_in_resp", 64'({busy, avm_read}), 64'b10);
    rst_n = 1'b0;
    #1;
    check("arst_ctrl", 64'({busy, done, avm_read, fifo_wrreq, fifo_rdreq, mac_clr, mac_en, fifo_wdata}), 64'd0);
    check("arst_addr", 64'(avm_address), 64'd0);
    pend = 1'b0;
    clear_stats();
    tick();
    tick();
    rst_n = 1'b1;
    spurious = 1'b1;
    repeat (8) tick();
    check("post_rst_writes", 64'(wr_total), 64'd0);
    check("post_rst_busy",   64'(busy),     64'd0);
    check("post_rst_reads",  64'(acc_q.size()), 64'd0);

    // Fresh run after the abandoned one
    clear_stats();
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    run_to_done("run4");
    check_run("run4", T_NOM);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
